// File: rtl/mem_req_arbiter.sv
// Arbitrates the icache (client 0) and dcache (client 1) onto one tagged memory bus and
// routes returning load data to whichever client owns the tag.
module mem_req_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_TAGS     = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            c0_req_valid,
    input  logic [XLEN-1:0] c0_req_addr,
    output logic            c0_req_ready,
    input  logic            c1_req_valid,
    input  logic [1:0]      c1_req_cmd,
    input  logic [XLEN-1:0] c1_req_addr,
    input  logic [63:0]     c1_req_data,
    output logic            c1_req_ready,
    output logic [3:0]      c0_issue_tag,
    output logic            c0_issue_valid,
    output logic [3:0]      c1_issue_tag,
    output logic            c1_issue_valid,
    output logic            c0_rsp_valid,
    output logic [3:0]      c0_rsp_tag,
    output logic [63:0]     c0_rsp_data,
    output logic            c1_rsp_valid,
    output logic [3:0]      c1_rsp_tag,
    output logic [63:0]     c1_rsp_data,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic            spurious_tag
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StIdle, StHold} state_e;

    state_e              state_q;
    logic [1:0]          hold_cmd_q;
    logic [XLEN-1:0]     hold_addr_q;
    logic [63:0]         hold_data_q;
    logic                hold_owner_q;
    logic [CntW-1:0]     starve_cnt_q;
    logic [NUM_TAGS-1:0] tbl_valid_q;
    logic [NUM_TAGS-1:0] tbl_owner_q;
    logic                spurious_q;

    logic accept, can_latch, c0_wins, c1_wins, grant0, grant1;
    logic tag_seen, rsp_hit, rsp_owner;

    always_comb begin
        accept    = (state_q == StHold) && (mem2proc_response != 4'd0);
        can_latch = (state_q == StIdle) || accept;
        // Client 1 has priority unless client 0 has been passed over too many times.
        c0_wins   = c0_req_valid && (!c1_req_valid || (starve_cnt_q >= CntW'(STARVE_LIMIT)));
        c1_wins   = c1_req_valid && !c0_wins;
        grant0    = can_latch && c0_wins;
        grant1    = can_latch && c1_wins;
        tag_seen  = (mem2proc_tag != 4'd0);
        rsp_hit   = tag_seen && tbl_valid_q[mem2proc_tag];
        rsp_owner = tbl_owner_q[mem2proc_tag];
    end

    assign c0_req_ready     = grant0;
    assign c1_req_ready     = grant1;
    assign c0_issue_valid   = accept && !hold_owner_q;
    assign c1_issue_valid   = accept && hold_owner_q;
    assign c0_issue_tag     = c0_issue_valid ? mem2proc_response : 4'd0;
    assign c1_issue_tag     = c1_issue_valid ? mem2proc_response : 4'd0;
    assign c0_rsp_valid     = rsp_hit && !rsp_owner;
    assign c1_rsp_valid     = rsp_hit && rsp_owner;
    assign c0_rsp_tag       = c0_rsp_valid ? mem2proc_tag : 4'd0;
    assign c1_rsp_tag       = c1_rsp_valid ? mem2proc_tag : 4'd0;
    assign c0_rsp_data      = c0_rsp_valid ? mem2proc_data : 64'd0;
    assign c1_rsp_data      = c1_rsp_valid ? mem2proc_data : 64'd0;
    assign proc2mem_command = (state_q == StHold) ? hold_cmd_q : BUS_NONE;
    assign proc2mem_addr    = (state_q == StHold) ? hold_addr_q : '0;
    assign proc2mem_data    = (state_q == StHold) ? hold_data_q : 64'd0;
    assign spurious_tag     = spurious_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            hold_cmd_q   <= BUS_NONE;
            hold_addr_q  <= '0;
            hold_data_q  <= 64'd0;
            hold_owner_q <= 1'b0;
            starve_cnt_q <= '0;
            tbl_valid_q  <= '0;
            tbl_owner_q  <= '0;
            spurious_q   <= 1'b0;
        end else begin
            if (grant0) begin
                state_q      <= StHold;
                hold_cmd_q   <= BUS_LOAD;
                hold_addr_q  <= c0_req_addr;
                hold_data_q  <= 64'd0;
                hold_owner_q <= 1'b0;
            end else if (grant1) begin
                state_q      <= StHold;
                hold_cmd_q   <= c1_req_cmd;
                hold_addr_q  <= c1_req_addr;
                hold_data_q  <= c1_req_data;
                hold_owner_q <= 1'b1;
            end else if (accept) begin
                state_q <= StIdle;
            end

            if (grant0) begin
                starve_cnt_q <= '0;
            end else if (grant1 && c0_req_valid && (starve_cnt_q < CntW'(STARVE_LIMIT))) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end

            // Clear first so a same-cycle reissue of the returning tag overrides it.
            if (rsp_hit) begin
                tbl_valid_q[mem2proc_tag] <= 1'b0;
            end
            if (accept && (hold_cmd_q == BUS_LOAD)) begin
                tbl_valid_q[mem2proc_response] <= 1'b1;
                tbl_owner_q[mem2proc_response] <= hold_owner_q;
            end

            if (tag_seen && !tbl_valid_q[mem2proc_tag]) begin
                spurious_q <= 1'b1;
            end
        end
    end

endmodule
